// File: rtl/pc_shot_engine.sv
// pc_shot_engine: computer opponent, fires one shot per PC turn.
// Optional PC_HUNT_EN: probe neighbours of the last unsunk hit first.
module pc_shot_engine #(
    parameter int         GRID_W     = 5,
    parameter int         GRID_H     = 5,
    parameter int         INIT_BOATS = 5,
    parameter logic [7:0] LFSR_SEED  = 8'hA5,
    parameter int         MAX_TRIES  = 32,
    localparam int        CELLS      = GRID_W * GRID_H,
    localparam int        IDX_W      = (CELLS > 1) ? $clog2(CELLS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       state,
    output logic [IDX_W-1:0] board_addr,
    input  logic [2:0]       board_data,
    output logic             pc_mov,
    output logic [3:0]       shot_x,
    output logic [3:0]       shot_y,
    output logic             shot_hit,
    output logic             shot_sunk,
    output logic [2:0]       boats_player
);

    localparam int               NSLOT    = 1 << IDX_W;
    localparam int               TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [IDX_W:0]   CELLS_L  = (IDX_W + 1)'(CELLS);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [2:0]       BOATS_L  = 3'(INIT_BOATS);
    localparam logic [2:0]       ST_START = 3'd0;
    localparam logic [2:0]       ST_PC    = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_PICK, S_SCAN, S_READ, S_RESOLVE, S_DONE, S_WAIT
    } eng_t;

    eng_t             eng, eng_nxt;
    logic [7:0]       lfsr;
    logic [NSLOT-1:0] fired;
    logic [IDX_W:0]   fired_cnt;
    logic [2:0]       hit_cnt [8];
    logic [TRY_W-1:0] tries;
    logic [IDX_W-1:0] scan_idx, cand, take_idx;
    logic             is_pc, is_start, all_fired, cand_ok;
    logic             take, reject, go_scan, scan_step, empty_shot;
    logic             data_hit, sink;
    logic [3:0]       res_x, res_y;

    assign is_pc     = state == ST_PC;
    assign is_start  = state == ST_START;
    assign cand      = lfsr[IDX_W-1:0];
    assign cand_ok   = ({1'b0, cand} < CELLS_L) && !fired[cand];
    assign all_fired = fired_cnt == CELLS_L;
    // ids above the fleet size are treated as water
    assign data_hit  = (board_data != 3'd0) && (board_data <= BOATS_L);
    assign sink      = data_hit &&
                       (hit_cnt[board_data] + 3'd1 == board_data);
    assign res_x     = 4'(int'(board_addr) % GRID_W);
    assign res_y     = 4'(int'(board_addr) / GRID_W);

`ifdef PC_HUNT_EN
    logic             hunt_vld, hunt_adv, nb_on, nb_ok;
    logic [1:0]       hunt_dir;
    logic [3:0]       hunt_x, hunt_y, nb_x, nb_y;
    logic [IDX_W-1:0] nb_idx;

    always_comb begin
        nb_x  = hunt_x;
        nb_y  = hunt_y;
        nb_on = 1'b0;
        unique case (hunt_dir)
            2'd0: begin
                nb_on = hunt_y != 4'd0;
                nb_y  = hunt_y - 4'd1;
            end
            2'd1: begin
                nb_on = int'(hunt_x) < GRID_W - 1;
                nb_x  = hunt_x + 4'd1;
            end
            2'd2: begin
                nb_on = int'(hunt_y) < GRID_H - 1;
                nb_y  = hunt_y + 4'd1;
            end
            default: begin
                nb_on = hunt_x != 4'd0;
                nb_x  = hunt_x - 4'd1;
            end
        endcase
        nb_idx = IDX_W'(int'(nb_y) * GRID_W + int'(nb_x));
        nb_ok  = nb_on && !fired[nb_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hunt_vld <= 1'b0;
            hunt_dir <= 2'd0;
            hunt_x   <= 4'd0;
            hunt_y   <= 4'd0;
        end else if (is_start) begin
            hunt_vld <= 1'b0;
        end else if (eng == S_RESOLVE) begin
            if (sink) begin
                hunt_vld <= 1'b0;
            end else if (data_hit) begin
                hunt_vld <= 1'b1;
                hunt_dir <= 2'd0;
                hunt_x   <= res_x;
                hunt_y   <= res_y;
            end
        end else if (hunt_adv) begin
            hunt_dir <= hunt_dir + 2'd1;
            if (hunt_dir == 2'd3)
                hunt_vld <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            eng <= S_IDLE;
        else
            eng <= eng_nxt;
    end

    always_comb begin
        eng_nxt    = eng;
        pc_mov     = 1'b0;
        take       = 1'b0;
        take_idx   = cand;
        reject     = 1'b0;
        go_scan    = 1'b0;
        scan_step  = 1'b0;
        empty_shot = 1'b0;
`ifdef PC_HUNT_EN
        hunt_adv   = 1'b0;
`endif
        unique case (eng)
            S_IDLE: if (is_pc) eng_nxt = S_PICK;
            S_PICK: begin
                if (!is_pc) begin
                    eng_nxt = S_IDLE;
                end else if (all_fired) begin
                    empty_shot = 1'b1;
                    eng_nxt    = S_DONE;
`ifdef PC_HUNT_EN
                end else if (hunt_vld) begin
                    hunt_adv = 1'b1;
                    if (nb_ok) begin
                        take     = 1'b1;
                        take_idx = nb_idx;
                        eng_nxt  = S_READ;
                    end
`endif
                end else if (cand_ok) begin
                    take    = 1'b1;
                    eng_nxt = S_READ;
                end else begin
                    reject = 1'b1;
                    if (tries == TRY_LAST) begin
                        go_scan = 1'b1;
                        eng_nxt = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (!is_pc) begin
                    eng_nxt = S_IDLE;
                end else if (!fired[scan_idx]) begin
                    take     = 1'b1;
                    take_idx = scan_idx;
                    eng_nxt  = S_READ;
                end else begin
                    scan_step = 1'b1;
                end
            end
            S_READ:    eng_nxt = is_pc ? S_RESOLVE : S_IDLE;
            S_RESOLVE: eng_nxt = S_DONE;
            S_DONE: begin
                pc_mov  = 1'b1;
                eng_nxt = S_WAIT;
            end
            S_WAIT:  if (!is_pc) eng_nxt = S_IDLE;
            default: eng_nxt = S_IDLE;
        endcase
        if (is_start)
            eng_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr         <= LFSR_SEED;
            fired        <= '0;
            fired_cnt    <= '0;
            tries        <= '0;
            scan_idx     <= '0;
            board_addr   <= '0;
            shot_x       <= 4'd0;
            shot_y       <= 4'd0;
            shot_hit     <= 1'b0;
            shot_sunk    <= 1'b0;
            boats_player <= BOATS_L;
            for (int i = 0; i < 8; i++)
                hit_cnt[i] <= 3'd0;
        end else begin
            if (eng == S_PICK)
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (eng == S_IDLE)
                tries <= '0;
            else if (reject)
                tries <= tries + TRY_W'(1);
            if (go_scan)
                scan_idx <= '0;
            else if (scan_step)
                scan_idx <= scan_idx + IDX_W'(1);
            // board_addr doubles as the chosen cell until the next pick
            if (take)
                board_addr <= take_idx;
            if (empty_shot) begin
                shot_hit  <= 1'b0;
                shot_sunk <= 1'b0;
            end
            if (eng == S_RESOLVE) begin
                fired[board_addr] <= 1'b1;
                fired_cnt         <= fired_cnt + (IDX_W + 1)'(1);
                shot_x            <= res_x;
                shot_y            <= res_y;
                shot_hit          <= data_hit;
                shot_sunk         <= sink;
                if (data_hit)
                    hit_cnt[board_data] <= hit_cnt[board_data] + 3'd1;
                if (sink && boats_player != 3'd0)
                    boats_player <= boats_player - 3'd1;
            end
            if (is_start) begin
                fired        <= '0;
                fired_cnt    <= '0;
                boats_player <= BOATS_L;
                for (int i = 0; i < 8; i++)
                    hit_cnt[i] <= 3'd0;
            end
        end
    end

endmodule
